// File: rtl/mpu_i2c_responder_if.sv
// mpu_i2c_responder_if: two-wire bus pins and register-file access port of the MPU_6050 responder.
interface mpu_i2c_responder_if #(
    parameter int DATA_I2C_SZ = 8,
    parameter int REG_ADDR_SZ = 8
);
    logic                   I_SCL;
    logic                   I_SDA;
    logic                   O_SDA_OE;
    logic [REG_ADDR_SZ-1:0] O_REG_ADDR;
    logic [DATA_I2C_SZ-1:0] O_REG_WDATA;
    logic                   O_REG_WE;
    logic                   O_REG_RD;
    logic [DATA_I2C_SZ-1:0] I_REG_RDATA;
    logic                   O_BUSY;
    modport slave (
        input  I_SCL, I_SDA, I_REG_RDATA,
        output O_SDA_OE, O_REG_ADDR, O_REG_WDATA, O_REG_WE, O_REG_RD, O_BUSY
    );
    modport master (
        output I_SCL, I_SDA, I_REG_RDATA,
        input  O_SDA_OE, O_REG_ADDR, O_REG_WDATA, O_REG_WE, O_REG_RD, O_BUSY
    );
endinterface

// File: rtl/mpu_i2c_responder.sv
// mpu_i2c_responder: I2C slave emulating the MPU_6050 register interface, with
// oversampled SCL/SDA, open-drain ACK/read drive and a single-port register access port.
module mpu_i2c_responder #(
    parameter logic [6:0] SLV_ADDR    = 7'h68,
    parameter int         ADDR_I2C_SZ = 7,
    parameter int         DATA_I2C_SZ = 8,
    parameter int         REG_ADDR_SZ = 8
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    mpu_i2c_responder_if.slave   bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    localparam logic [3:0] LAST = 4'(DATA_I2C_SZ - 1);
    localparam logic [3:0] NBIT = 4'(DATA_I2C_SZ);

    state_t                 r_state;
    logic [1:0]             r_scl_s, r_sda_s;
    logic                   r_scl_p, r_sda_p;
    logic [3:0]             r_cnt;
    logic [DATA_I2C_SZ-2:0] r_shift;
    logic [DATA_I2C_SZ-1:0] r_tx;
    logic [REG_ADDR_SZ-1:0] r_ptr;
    logic                   r_rw, r_rd_d;

    wire                   w_scl      = r_scl_s[1];
    wire                   w_sda      = r_sda_s[1];
    wire                   w_scl_rise = w_scl & ~r_scl_p;
    wire                   w_scl_fall = ~w_scl & r_scl_p;
    wire                   w_start    = w_scl & r_scl_p & ~w_sda & r_sda_p;
    wire                   w_stop     = w_scl & r_scl_p & w_sda & ~r_sda_p;
    wire [DATA_I2C_SZ-1:0] w_byte     = {r_shift, w_sda};

    assign bus.O_BUSY = (r_state != IDLE) && (r_state != IGNORE);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state         <= IDLE;
            r_scl_s         <= '0;
            r_sda_s         <= '0;
            r_scl_p         <= 1'b0;
            r_sda_p         <= 1'b0;
            r_cnt           <= '0;
            r_shift         <= '0;
            r_tx            <= '0;
            r_ptr           <= '0;
            r_rw            <= 1'b0;
            r_rd_d          <= 1'b0;
            bus.O_SDA_OE    <= 1'b0;
            bus.O_REG_ADDR  <= '0;
            bus.O_REG_WDATA <= '0;
            bus.O_REG_WE    <= 1'b0;
            bus.O_REG_RD    <= 1'b0;
        end else begin
            r_scl_s      <= {r_scl_s[0], bus.I_SCL};
            r_sda_s      <= {r_sda_s[0], bus.I_SDA};
            r_scl_p      <= w_scl;
            r_sda_p      <= w_sda;
            r_rd_d       <= bus.O_REG_RD;
            bus.O_REG_WE <= 1'b0;
            bus.O_REG_RD <= 1'b0;
            if (w_start) begin
                r_state      <= ADDR;
                r_cnt        <= '0;
                bus.O_SDA_OE <= 1'b0;
            end else if (w_stop) begin
                r_state      <= IDLE;
                r_cnt        <= '0;
                bus.O_SDA_OE <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, PTR, WR_DATA: if (w_scl_rise) begin
                        r_shift <= w_byte[DATA_I2C_SZ-2:0];
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == LAST) begin
                            r_cnt <= '0;
                            if (r_state == ADDR) begin
                                // the read pointer is fetched during the address byte so data is ready at the first fall
                                if (r_shift[ADDR_I2C_SZ-1:0] == SLV_ADDR) begin
                                    r_state <= ADDR_ACK;
                                    r_rw    <= w_sda;
                                    if (w_sda) begin
                                        bus.O_REG_RD   <= 1'b1;
                                        bus.O_REG_ADDR <= r_ptr;
                                        r_ptr          <= r_ptr + 1'b1;
                                    end
                                end else begin
                                    r_state <= IGNORE;
                                end
                            end else if (r_state == PTR) begin
                                r_ptr   <= REG_ADDR_SZ'(w_byte);
                                r_state <= PTR_ACK;
                            end else begin
                                bus.O_REG_WE    <= 1'b1;
                                bus.O_REG_ADDR  <= r_ptr;
                                bus.O_REG_WDATA <= w_byte;
                                r_ptr           <= r_ptr + 1'b1;
                                r_state         <= WR_ACK;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WR_ACK: begin
                        // r_cnt marks that the 9th clock has risen; its fall ends the ACK
                        if (w_scl_rise) begin
                            r_cnt <= 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_cnt == 4'd0) begin
                                bus.O_SDA_OE <= 1'b1;
                            end else begin
                                r_cnt <= '0;
                                if (r_state == ADDR_ACK && r_rw) begin
                                    bus.O_SDA_OE <= ~r_tx[DATA_I2C_SZ-1];
                                    r_tx         <= {r_tx[DATA_I2C_SZ-2:0], 1'b0};
                                    r_state      <= RD_DATA;
                                end else begin
                                    bus.O_SDA_OE <= 1'b0;
                                    r_state      <= (r_state == ADDR_ACK) ? PTR : WR_DATA;
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_cnt == NBIT) begin
                                r_cnt        <= '0;
                                bus.O_SDA_OE <= 1'b0;
                                r_state      <= RD_ACK;
                            end else begin
                                bus.O_SDA_OE <= ~r_tx[DATA_I2C_SZ-1];
                                r_tx         <= {r_tx[DATA_I2C_SZ-2:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= IGNORE;
                            end else begin
                                r_cnt          <= 4'd1;
                                bus.O_REG_RD   <= 1'b1;
                                bus.O_REG_ADDR <= r_ptr;
                                r_ptr          <= r_ptr + 1'b1;
                            end
                        end else if (w_scl_fall && r_cnt == 4'd1) begin
                            r_cnt        <= '0;
                            bus.O_SDA_OE <= ~r_tx[DATA_I2C_SZ-1];
                            r_tx         <= {r_tx[DATA_I2C_SZ-2:0], 1'b0};
                            r_state      <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
            if (r_rd_d) r_tx <= bus.I_REG_RDATA;
        end
    end
endmodule

// File: tb/tb_mpu_i2c_responder.sv
// tb_mpu_i2c_responder: bit-banged I2C master against the responder with a
// register model returning addr^0xA5 (0x68 at WHO_AM_I).
module tb_mpu_i2c_responder;
    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #10 CLK = ~CLK;

    mpu_i2c_responder_if bus ();
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic [7:0] mem [256];
    logic [7:0] r_rdata = 8'h00;
    assign bus.I_SCL       = m_scl;
    assign bus.I_SDA       = m_sda & ~bus.O_SDA_OE;
    assign bus.I_REG_RDATA = r_rdata;

    mpu_i2c_responder dut (.CLK(CLK), .RST_n(RST_n), .bus(bus));

    always @(posedge CLK) begin
        if (bus.O_REG_WE) mem[bus.O_REG_ADDR] <= bus.O_REG_WDATA;
        if (bus.O_REG_RD) r_rdata <= mem[bus.O_REG_ADDR];
    end

    logic [7:0] we_a [$];
    logic [7:0] we_d [$];
    logic [7:0] rd_a [$];
    logic       oe_seen = 1'b0;
    always @(negedge CLK) begin
        if (bus.O_REG_WE) begin
            we_a.push_back(bus.O_REG_ADDR);
            we_d.push_back(bus.O_REG_WDATA);
        end
        if (bus.O_REG_RD) rd_a.push_back(bus.O_REG_ADDR);
        if (bus.O_SDA_OE) oe_seen = 1'b1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic i2c_start();
        m_sda = 1'b0; clks(16);
        m_scl = 1'b0; clks(8);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; clks(8);
        m_scl = 1'b1; clks(16);
        m_sda = 1'b0; clks(16);
        m_scl = 1'b0; clks(8);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; clks(8);
        m_scl = 1'b1; clks(16);
        m_sda = 1'b1; clks(16);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    clks(8);
        m_scl = 1'b1; clks(16);
        m_scl = 1'b0; clks(8);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; clks(8);
        m_scl = 1'b1; clks(8);
        b = bus.I_SDA; clks(8);
        m_scl = 1'b0; clks(8);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        send_bit(nack);
    endtask

    task automatic clear_mon();
        we_a.delete(); we_d.delete(); rd_a.delete();
        oe_seen = 1'b0;
    endtask

    logic       a0, a1, a2;
    logic [7:0] d0, d1, d2;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h75] = 8'h68;
        clks(5);
        check("rst_oe", bus.O_SDA_OE, 0);
        check("rst_busy", bus.O_BUSY, 0);
        check("rst_we_rd", {bus.O_REG_WE, bus.O_REG_RD}, 0);
        check("rst_addr_wdata", {bus.O_REG_ADDR, bus.O_REG_WDATA}, 0);
        RST_n = 1'b1;
        clks(10);

        // single register write
        clear_mon();
        i2c_start();
        send_byte(8'hD0, a0);
        check("wr_busy", bus.O_BUSY, 1);
        send_byte(8'h6B, a1);
        send_byte(8'h00, a2);
        i2c_stop();
        check("wr_acks", {a0, a1, a2}, 3'b111);
        check("wr_we_cnt", we_a.size(), 1);
        if (we_a.size() == 1) check("wr_we", {we_a[0], we_d[0]}, 16'h6B00);
        check("wr_busy_after", bus.O_BUSY, 0);
        // current-address read shows the pointer moved to 0x6C
        clear_mon();
        i2c_start();
        send_byte(8'hD1, a0);
        recv_byte(d0, 1'b1);
        i2c_stop();
        check("ptr_ack", a0, 1);
        check("ptr_data", d0, 8'hC9);
        check("ptr_rd_cnt", rd_a.size(), 1);
        if (rd_a.size() == 1) check("ptr_rd_addr", rd_a[0], 8'h6C);

        // burst read 0x3B..0x3D
        clear_mon();
        i2c_start();
        send_byte(8'hD0, a0);
        send_byte(8'h3B, a1);
        i2c_rstart();
        send_byte(8'hD1, a2);
        recv_byte(d0, 1'b0);
        recv_byte(d1, 1'b0);
        recv_byte(d2, 1'b1);
        i2c_stop();
        check("brd_acks", {a0, a1, a2}, 3'b111);
        check("brd_data", {d0, d1, d2}, 24'h9E9998);
        check("brd_rd_cnt", rd_a.size(), 3);
        if (rd_a.size() == 3) check("brd_rd_addr", {rd_a[0], rd_a[1], rd_a[2]}, 24'h3B3C3D);
        check("brd_we_cnt", we_a.size(), 0);

        // WHO_AM_I
        clear_mon();
        i2c_start();
        send_byte(8'hD0, a0);
        send_byte(8'h75, a1);
        i2c_rstart();
        send_byte(8'hD1, a2);
        recv_byte(d0, 1'b1);
        check("who_data", d0, 8'h68);
        check("who_ignore_busy", bus.O_BUSY, 0);
        clks(40);
        check("who_ignore_oe", bus.O_SDA_OE, 0);
        i2c_stop();
        check("who_rd_cnt", rd_a.size(), 1);

        // foreign address
        clear_mon();
        i2c_start();
        send_byte(8'hA0, a0);
        check("mis_busy", bus.O_BUSY, 0);
        send_byte(8'h11, a1);
        i2c_stop();
        check("mis_acks", {a0, a1}, 2'b00);
        check("mis_oe_seen", oe_seen, 0);
        check("mis_strobes", we_a.size() + rd_a.size(), 0);

        // pointer wrap
        clear_mon();
        i2c_start();
        send_byte(8'hD0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a0);
        i2c_stop();
        check("wrap_we_cnt", we_a.size(), 2);
        if (we_a.size() == 2) check("wrap_we", {we_a[0], we_d[0], we_a[1], we_d[1]}, 32'hFF11_0022);

        // partial data byte aborted by STOP
        clear_mon();
        i2c_start();
        send_byte(8'hD0, a0);
        send_byte(8'h10, a1);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        i2c_stop();
        check("abort_we_cnt", we_a.size(), 0);
        check("abort_busy", bus.O_BUSY, 0);

        // reset while the ACK bit holds SDA low
        clear_mon();
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 6 || i == 4);
        check("rst_pre_oe", bus.O_SDA_OE, 1);
        RST_n = 1'b0;
        #1;
        check("rst_async_oe", bus.O_SDA_OE, 0);
        check("rst_async_busy", bus.O_BUSY, 0);
        check("rst_async_wdata", bus.O_REG_WDATA, 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        clks(4);
        RST_n = 1'b1;
        clks(10);
        // pointer restarts at 0 after reset
        clear_mon();
        i2c_start();
        send_byte(8'hD1, a0);
        recv_byte(d0, 1'b1);
        i2c_stop();
        check("post_rst_data", d0, 8'h22);
        if (rd_a.size() == 1) check("post_rst_rd_addr", rd_a[0], 8'h00);
        else check("post_rst_rd_cnt", rd_a.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
